// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master. It turns a valid/ready command stream into APB
// SETUP/ACCESS transfers and returns read data and error status on a response channel.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready, and a
  // response on an edge where rsp_valid && rsp_ready. A valid stays high and its
  // payload stays stable until it has transferred.

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] WAIT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  // wait_cnt holds the number of earlier wait cycles, so it equals TIMEOUT_CYCLES-1
  // during the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign timeout_hit = TO_EN && (wait_cnt == WAIT_LAST);
  assign cmd_ready   = (state == S_IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            PADDR    <= cmd_addr;
            PWRITE   <= cmd_write;
            PWDATA   <= cmd_wdata;
            PSELx    <= 1'b1;
            PENABLE  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY takes priority over a timeout that would fire on the same edge.
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= S_RESP;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: the bench plays the APB slave and checks bus
// timing, response contents, backpressure and asynchronous reset against hand-computed values.
module tb_apb_master_bridge;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  int total;
  int bad;

  // Expected response packed as {timeout, err, rdata}.
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] last_exp;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  // Clock and watchdog
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Issue one command and play the slave. waits = PREADY-low ACCESS cycles before
  // PREADY=1; hang holds PREADY low so the bridge must time out.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int waits, input logic hang, input logic [DW-1:0] rd,
                          input logic se, input logic [DW+1:0] exp_rsp);
    int n_access;
    exp_q.push_back(exp_rsp);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    PREADY = 1'b0; PRDATA = rd; PSLVERR = se;
    check("idle_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    cmd_wdata = ~wd;
    check("setup_psel", PSELx, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_paddr", PADDR, a);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wd);
    tick();
    n_access = hang ? TO : waits + 1;
    for (int k = 0; k < n_access; k++) begin
      check("access_psel", PSELx, 1);
      check("access_penable", PENABLE, 1);
      check("access_paddr", PADDR, a);
      check("access_pwdata", PWDATA, wd);
      check("access_rsp_valid", rsp_valid, 0);
      PREADY = (!hang && k == waits);
      tick();
    end
    PREADY = 1'b0;
    last_exp = exp_q.pop_front();
    check("done_rsp_valid", rsp_valid, 1);
    check("done_psel", PSELx, 0);
    check("done_penable", PENABLE, 0);
    check("done_rdata", rsp_rdata, last_exp[DW-1:0]);
    check("done_err", rsp_err, last_exp[DW]);
    check("done_timeout", rsp_timeout, last_exp[DW+1]);
  endtask

  // Hold rsp_ready low for hold cycles, keeping cmd_valid high to show it is ignored.
  task automatic consume(input int hold);
    cmd_valid = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      rsp_ready = 1'b0;
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_psel", PSELx, 0);
      check("bp_rdata", rsp_rdata, last_exp[DW-1:0]);
      check("bp_err", rsp_err, last_exp[DW]);
      check("bp_timeout", rsp_timeout, last_exp[DW+1]);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("consumed_rsp_valid", rsp_valid, 0);
    check("consumed_cmd_ready", cmd_ready, 1);
    check("consumed_psel", PSELx, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;

    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    PRESETn = 1'b1;
    tick();

    // Zero-wait write: response after edge N+2, rdata forced to 0.
    run_xfer(1'b1, 4'h2, 16'h00A5, 0, 1'b0, 16'hFFFF, 1'b0, {2'b00, 16'h0000});
    consume(0);
    check("idle_holds_paddr", PADDR, 4'h2);
    check("idle_holds_pwdata", PWDATA, 16'h00A5);

    // Read with 3 wait states.
    run_xfer(1'b0, 4'h5, 16'h0000, 3, 1'b0, 16'h1234, 1'b0, {2'b00, 16'h1234});
    consume(0);

    // Slave error on a read keeps the read data.
    run_xfer(1'b0, 4'h7, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b1, {2'b01, 16'hBEEF});
    consume(0);

    // Hung slave: abort after 16 wait cycles.
    run_xfer(1'b0, 4'h3, 16'h0000, 0, 1'b1, 16'hFFFF, 1'b0, {2'b11, 16'h0000});
    consume(0);

    // PREADY arrives on the 16th ACCESS cycle: normal completion.
    run_xfer(1'b0, 4'h3, 16'h0000, 15, 1'b0, 16'h5A5A, 1'b0, {2'b00, 16'h5A5A});
    consume(0);

    // Write with slave error, then 5 cycles of response backpressure.
    run_xfer(1'b1, 4'hF, 16'hFFFF, 1, 1'b0, 16'h9999, 1'b1, {2'b01, 16'h0000});
    consume(5);
    // cmd_valid is still high: accepted on the very next edge.
    run_xfer(1'b0, 4'h9, 16'h0000, 0, 1'b0, 16'hC3C3, 1'b0, {2'b00, 16'hC3C3});
    consume(0);

    // Asynchronous reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hA; cmd_wdata = 16'h7777;
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_penable", PENABLE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_rst_psel", PSELx, 0);
    check("async_rst_penable", PENABLE, 0);
    check("async_rst_paddr", PADDR, 0);
    check("async_rst_pwdata", PWDATA, 0);
    check("async_rst_pwrite", PWRITE, 0);
    check("async_rst_cmd_ready", cmd_ready, 1);
    check("async_rst_rsp_valid", rsp_valid, 0);
    #2;
    PRESETn = 1'b1;
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_rsp_valid", rsp_valid, 0);
      check("post_rst_psel", PSELx, 0);
    end
    PREADY = 1'b0;
    rsp_ready = 1'b0;

    // Recovery after reset.
    run_xfer(1'b1, 4'h1, 16'h0001, 2, 1'b0, 16'hAAAA, 1'b0, {2'b00, 16'h0000});
    consume(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB master. Converts a valid/ready command stream from the host-side controller or testbench sequencer into APB SETUP/ACCESS transfers.
- Drives the APB UART slave's bus pins and returns read data and error status on a valid/ready response channel.
- Sits directly upstream of the UART APB slave. Includes a wait-state timeout so a hung slave cannot stall the host.

Parameters:
- ADDR_WIDTH, 4, APB address width; matches the UART slave.
- DATA_WIDTH, 16, APB data width (8/16/32).
- TIMEOUT_CYCLES, 16, consecutive ACCESS cycles with PREADY=0 before the transfer is aborted. 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; sole clock.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host consumes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  set only for a timeout abort.
- PADDR  out  ADDR_WIDTH  APB address.
- PSELx  out  1  slave select.
- PENABLE  out  1  access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERR  in  1  slave error.

Behaviour:
- One clock (PCLK); reset is asynchronous, active-low (PRESETn). All outputs are registered except cmd_ready.
- Reset values: state=IDLE; PSELx, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout = 0; PADDR, PWDATA and rsp_rdata = 0; wait counter = 0. cmd_ready=1 immediately after reset.
- Reset asserted mid-transfer: the bus returns to idle asynchronously and no response is produced for the dropped command.
- State machine (IDLE, SETUP, ACCESS, RESP):
  - IDLE: cmd_ready=1. If cmd_valid=1 at the edge, capture cmd_addr, cmd_write and cmd_wdata into PADDR, PWRITE and PWDATA. Set PSELx=1, PENABLE=0, go to SETUP.
  - SETUP: lasts exactly one cycle. Next edge sets PENABLE=1, go to ACCESS.
  - ACCESS: PSELx=1, PENABLE=1.
    - PREADY=1 at the edge: capture rsp_rdata = PWRITE ? 0 : PRDATA and rsp_err = PSLVERR, with rsp_timeout=0. Set rsp_valid=1, PSELx=0, PENABLE=0, go to RESP.
    - PREADY=0: increment the wait counter.
    - If TIMEOUT_CYCLES>0 and this is the TIMEOUT_CYCLES-th consecutive PREADY=0 ACCESS cycle: set rsp_err=1, rsp_timeout=1, rsp_rdata=0, deassert PSELx and PENABLE, go to RESP.
    - PREADY=1 on the same edge that would time out: PREADY wins and the transfer completes normally.
  - RESP: rsp_valid held with rsp_rdata, rsp_err and rsp_timeout stable until rsp_ready=1 at an edge. Then rsp_valid=0, go to IDLE. cmd_ready=0 in RESP, so there is no back-to-back acceptance until the response is consumed.
- cmd_ready is low in SETUP, ACCESS and RESP. cmd_* inputs are ignored outside IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They hold their last values while idle and change only on command capture.
- PENABLE is never 1 while PSELx=0. PSELx and PENABLE go low together on the completion edge. PSELx is never asserted on two transfers without passing through IDLE.
- Wait counter: width $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. Cleared on entry to SETUP, saturates (never wraps).
- Latency with a zero-wait slave: command accepted at edge N → SETUP in cycle N..N+1, ACCESS in cycle N+1..N+2, rsp_valid=1 after edge N+2. Each slave wait state adds 1 cycle.
- With rsp_ready tied 1, throughput is one transfer per 4 cycles.

Test Plan:
- Write, zero-wait slave: cmd_write=1, addr=0x2, wdata=0x00A5 accepted at edge N. Expect PSELx=1 PENABLE=0 for 1 cycle, then PENABLE=1 with PADDR=0x2 and PWDATA=0x00A5 stable. rsp_valid=1 after edge N+2 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: PREADY low 3 ACCESS cycles, then high with PRDATA=0x1234. Expect rsp_rdata=0x1234 and rsp_valid after edge N+5; PADDR unchanged throughout.
- Slave error: read completes with PSLVERR=1 and PRDATA=0xBEEF. Expect rsp_err=1, rsp_timeout=0, rsp_rdata=0xBEEF.
- Timeout: TIMEOUT_CYCLES=16, PREADY held 0. Expect PSELx/PENABLE low after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 16th cycle → normal completion, rsp_timeout=0.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid held high. Expect cmd_ready=0 and response fields stable. After the rsp_ready=1 edge, rsp_valid=0 and the next command is accepted in IDLE one cycle later.
- Reset mid-ACCESS: assert PRESETn=0 asynchronously while PENABLE=1. Expect all outputs at reset values before the next PCLK edge and no rsp_valid after release.
